// File: rtl/vthernet_pkg.sv
// Shared SMI (MDIO management) constants, state encoding and frame helpers.
package vthernet_pkg;

  localparam logic [1:0]  SMI_ST        = 2'b01;
  localparam logic [1:0]  SMI_OP_RD     = 2'b10;
  localparam logic [1:0]  SMI_OP_WR     = 2'b01;
  localparam logic [1:0]  SMI_TA_WR     = 2'b10;
  localparam int unsigned SMI_PRE_LEN   = 32;
  localparam int unsigned SMI_FRAME_LEN = 64;
  localparam int unsigned SMI_CMD_LEN   = 14;
  localparam int unsigned SMI_TA_LEN    = 2;
  localparam int unsigned SMI_DATA_LEN  = SMI_FRAME_LEN - SMI_PRE_LEN - SMI_CMD_LEN - SMI_TA_LEN;
  localparam int unsigned SMI_BIT_W     = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    CMD  = 3'd2,
    TA   = 3'd3,
    DATA = 3'd4,
    FIN  = 3'd5
  } smi_state_e;

  typedef struct packed {
    logic        op_read;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic [15:0] wr_data;
  } smi_req_t;

  // Post-preamble bits of a frame, MSB sent first; read TA/DATA are placeholders (bus released).
  function automatic logic [31:0] smi_tail(input smi_req_t r);
    if (r.op_read) begin
      return {SMI_ST, SMI_OP_RD, r.phy_addr, r.reg_addr, 2'b11, 16'hFFFF};
    end
    return {SMI_ST, SMI_OP_WR, r.phy_addr, r.reg_addr, SMI_TA_WR, r.wr_data};
  endfunction

  // Index of the last bit spent in a frame-carrying state.
  function automatic logic [SMI_BIT_W-1:0] smi_last_bit(input smi_state_e s);
    case (s)
      PRE:     return SMI_BIT_W'(SMI_PRE_LEN - 1);
      CMD:     return SMI_BIT_W'(SMI_CMD_LEN - 1);
      TA:      return SMI_BIT_W'(SMI_TA_LEN - 1);
      default: return SMI_BIT_W'(SMI_DATA_LEN - 1);
    endcase
  endfunction

  // Frame phase that follows a completed phase.
  function automatic smi_state_e smi_after(input smi_state_e s);
    case (s)
      PRE:     return CMD;
      CMD:     return TA;
      TA:      return DATA;
      default: return FIN;
    endcase
  endfunction

endpackage

// File: rtl/smi_clkgen.sv
// MDC divider: low for CLK_DIV cycles then high for CLK_DIV cycles while enabled.
// mdc_fall / mdc_rise are high in the cycle whose closing edge makes MDC fall / rise.
module smi_clkgen
  import vthernet_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic en_i,
  output logic MDC,
  output logic mdc_fall,
  output logic mdc_rise
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          fall_q, fall_d;
  logic          rise_q, rise_d;

  // Half-period counter; strobes look one edge ahead so the controller acts on the MDC edge itself.
  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    fall_d = (cnt_d == LAST) && mdc_d;
    rise_d = (cnt_d == LAST) && !mdc_d;
  end

  // Divider state registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q  <= '0;
      mdc_q  <= 1'b0;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mdc_q  <= mdc_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign MDC      = mdc_q;
  assign mdc_fall = fall_q;
  assign mdc_rise = rise_q;

endmodule

// File: rtl/smi_controller.sv
// SMI/MDIO management frame controller: 32-bit preamble, command, turnaround, 16-bit data.
// Optional build macro SMI_PRE_SUPPRESS_EN adds pre_suppress to skip the preamble.
module smi_controller
  import vthernet_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        op_read,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
`ifdef SMI_PRE_SUPPRESS_EN
  input  logic        pre_suppress,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        MDC,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  smi_state_e            state_q, state_d;
  logic [SMI_BIT_W-1:0]  bit_q, bit_d;
  logic [31:0]           tx_q, tx_d;
  logic [15:0]           rx_q, rx_d;
  logic [15:0]           rd_q, rd_d;
  logic                  op_q, op_d;
  logic                  mdio_q, mdio_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  smi_req_t              req_c;
  logic [31:0]           tail_c;
  logic                  run_c;
  logic                  mdc_fall, mdc_rise;

  assign req_c  = {op_read, phy_addr, reg_addr, wr_data};
  assign tail_c = smi_tail(req_c);
  assign run_c  = state_q inside {PRE, CMD, TA, DATA};

  smi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .en_i     (run_c),
    .MDC      (MDC),
    .mdc_fall (mdc_fall),
    .mdc_rise (mdc_rise)
  );

  // Next-state and bit-level drive/sample logic.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    op_d    = op_q;
    mdio_d  = mdio_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_read;
          busy_d = 1'b1;
          bit_d  = '0;
          oe_d   = 1'b1;
          state_d = PRE;
          mdio_d  = 1'b1;
          tx_d    = tail_c;
`ifdef SMI_PRE_SUPPRESS_EN
          if (pre_suppress) begin
            state_d = CMD;
            mdio_d  = tail_c[31];
            tx_d    = {tail_c[30:0], 1'b0};
          end
`endif
        end
      end
      PRE, CMD, TA, DATA: begin
        if (mdc_rise && (state_q == DATA) && op_q) begin
          rx_d = {rx_q[14:0], mdio_i};
        end
        if (mdc_fall) begin
          if (bit_q == smi_last_bit(state_q)) begin
            bit_d   = '0;
            state_d = smi_after(state_q);
          end else begin
            bit_d = bit_q + SMI_BIT_W'(1);
          end
          if (state_d == FIN) begin
            oe_d = 1'b0;
          end else if (state_d == PRE) begin
            mdio_d = 1'b1;
          end else begin
            mdio_d = tx_q[31];
            tx_d   = {tx_q[30:0], 1'b0};
            oe_d   = !(op_q && (state_d inside {TA, DATA}));
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q) begin
          rd_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers; reset aborts any frame in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      op_q    <= 1'b0;
      mdio_q  <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      mdio_q  <= mdio_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_q;
  assign mdio_o  = mdio_q;
  assign mdio_oe = oe_q;

endmodule

// File: tb/tb_smi_controller.sv
// Bench for smi_controller: two instances (CLK_DIV 10 and 2), frame-level reference model and PHY model.
module tb_smi_controller;

  localparam int D1 = 10;
  localparam int D2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic        op_read;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wr_data;
  logic        mdio_i;
  logic        sup;

  logic        busy1, done1, mdc1, mo1, oe1;
  logic [15:0] rd1;
  logic        busy2, done2, mdc2, mo2, oe2;
  logic [15:0] rd2;

  always #5 clk = ~clk;

  smi_controller #(.CLK_DIV(D1)) u_dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .start (start1), .op_read (op_read),
    .phy_addr (phy_addr), .reg_addr (reg_addr), .wr_data (wr_data),
`ifdef SMI_PRE_SUPPRESS_EN
    .pre_suppress (sup),
`endif
    .busy (busy1), .done (done1), .rd_data (rd1), .MDC (mdc1),
    .mdio_o (mo1), .mdio_oe (oe1), .mdio_i (mdio_i)
  );

  smi_controller #(.CLK_DIV(D2)) u_dut2 (
    .wb_clk_i (clk), .wb_rst_i (rst), .start (start2), .op_read (op_read),
    .phy_addr (phy_addr), .reg_addr (reg_addr), .wr_data (wr_data),
`ifdef SMI_PRE_SUPPRESS_EN
    .pre_suppress (sup),
`endif
    .busy (busy2), .done (done2), .rd_data (rd2), .MDC (mdc2),
    .mdio_o (mo2), .mdio_oe (oe2), .mdio_i (mdio_i)
  );

  // Observation mux onto the instance under test.
  logic        sel;
  logic        m_busy, m_done, m_mdc, m_mo, m_oe;
  logic [15:0] m_rd;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_mdc  = sel ? mdc2  : mdc1;
  assign m_mo   = sel ? mo2   : mo1;
  assign m_oe   = sel ? oe2   : oe1;
  assign m_rd   = sel ? rd2   : rd1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_rd [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame on instance s; dup_at pulses a second start mid-frame, rst_bit resets after that many MDC rises.
  task automatic run_frame(input int s, input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] pd, input bit sp,
                           input int dup_at, input int rst_bit);
    int d, flen, pre, limit, idx;
    int bitn, n, last_rise, dones, done_at, period_bad, change_bad;
    logic        busy_at_done, pm, pmo;
    logic [15:0] rd_at_done, want_rd;
    logic [31:0] tail;
    logic [63:0] e_bits, e_oe, g_bits, g_oe, mask;
    bit          rx;

    d     = (s != 0) ? D2 : D1;
    flen  = sp ? 32 : 64;
    pre   = sp ? 0 : 32;
    limit = flen * 2 * d + 20;
    tail  = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra, 2'b10, wd};
    e_bits = '0; e_oe = '0; g_bits = '0; g_oe = '0; mask = '0;
    for (int i = 0; i < flen; i++) begin
      idx = 63 - i;
      e_bits[idx] = (i < pre) ? 1'b1 : tail[31 - (i - pre)];
      rx = rd && (i >= flen - 18);
      e_oe[idx] = !rx;
      mask[idx] = !rx;
    end
    bitn = 0; n = 0; last_rise = 0; dones = 0; done_at = -1;
    period_bad = 0; change_bad = 0; busy_at_done = 1'b1; rd_at_done = '0;

    @(negedge clk);
    sel = (s != 0);
    op_read = rd; phy_addr = pa; reg_addr = ra; wr_data = wd; sup = sp; mdio_i = 1'b1;
    if (s != 0) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    pm = 1'b0; pmo = m_mo;

    while (n <= limit) begin
      if (n == 0) check_eq("busy_after_start", 64'(m_busy), 64'd1);
      if (rst_bit >= 0 && bitn == rst_bit) begin
        rst = 1'b1;
        #1;
        check_eq("rst_outputs", {m_busy, m_done, m_mdc, m_mo, m_oe}, 64'b00010);
        check_eq("rst_rd_data", 64'(m_rd), 64'd0);
        exp_rd[0] = '0; exp_rd[1] = '0;
        dones = 0;
        repeat (4) begin
          @(negedge clk);
          if (m_done) dones++;
        end
        rst = 1'b0;
        check_eq("rst_no_done", 64'(dones), 64'd0);
        return;
      end
      if (m_mdc && !pm) begin
        if (bitn < 64) begin
          g_bits[63 - bitn] = m_mo;
          g_oe[63 - bitn]   = m_oe;
        end
        if (bitn > 0 && (n - last_rise) != 2 * d) period_bad++;
        last_rise = n;
        bitn++;
        if (rd && bitn >= flen - 16 && bitn < flen) mdio_i = pd[flen - 1 - bitn];
        else mdio_i = 1'($urandom);
      end
      if (n > 0 && m_mo !== pmo && !(pm && !m_mdc)) change_bad++;
      if (m_done) begin
        dones++;
        if (dones == 1) begin
          done_at = n; busy_at_done = m_busy; rd_at_done = m_rd;
        end
      end
      start1 = 1'b0; start2 = 1'b0;
      if (dup_at > 0 && n == dup_at) begin
        reg_addr = ~ra; op_read = ~rd;
        if (s != 0) start2 = 1'b1; else start1 = 1'b1;
      end
      pm = m_mdc; pmo = m_mo;
      @(negedge clk);
      n++;
    end

    want_rd = rd ? pd : exp_rd[s];
    check_eq("done_count", 64'(dones), 64'd1);
    check_eq("done_cycle", 64'(done_at), 64'(flen * 2 * d + 1));
    check_eq("busy_at_done", 64'(busy_at_done), 64'd0);
    check_eq("frame_bits", g_bits & mask, e_bits & mask);
    check_eq("mdio_oe_bits", g_oe, e_oe);
    check_eq("mdc_rises", 64'(bitn), 64'(flen));
    check_eq("mdc_period", 64'(period_bad), 64'd0);
    check_eq("mdio_hold", 64'(change_bad), 64'd0);
    check_eq("rd_data", 64'(rd_at_done), 64'(want_rd));
    check_eq("idle_busy", 64'(m_busy), 64'd0);
    exp_rd[s] = want_rd;
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; op_read = 1'b0;
    phy_addr = '0; reg_addr = '0; wr_data = '0; mdio_i = 1'b1; sup = 1'b0; sel = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = (i != 0);
      #1;
      check_eq("reset_outputs", {m_busy, m_done, m_mdc, m_mo, m_oe}, 64'b00010);
      check_eq("reset_rd_data", 64'(m_rd), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 1'b0, 5'd1, 5'd0, 16'h1140, 16'h0000, 1'b0, -1, -1);
    run_frame(0, 1'b1, 5'd3, 5'd2, 16'h0000, 16'h0141, 1'b0, -1, -1);
    run_frame(1, 1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0000, 1'b0, -1, -1);
    run_frame(0, 1'b0, 5'h0A, 5'h05, 16'hBEEF, 16'h0000, 1'b0, 300, -1);
    run_frame(0, 1'b1, 5'd7, 5'd9, 16'h0000, 16'h1234, 1'b0, -1, 40);
    run_frame(0, 1'b1, 5'd7, 5'd9, 16'h0000, 16'hA5C3, 1'b0, -1, -1);
    for (int i = 0; i < 10; i++) begin
      run_frame(i % 2, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                1'b0, -1, -1);
    end
`ifdef SMI_PRE_SUPPRESS_EN
    run_frame(0, 1'b0, 5'd4, 5'd17, 16'h5A0F, 16'h0000, 1'b1, -1, -1);
    run_frame(0, 1'b1, 5'd2, 5'd1, 16'h0000, 16'hC3E1, 1'b1, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
